board_state_regs: RTL and testbench

Parametrised board-state register file for the TicTacToe game and its larger-grid variants. It holds BOARD_DIM x BOARD_DIM cells, each storing a player code. Moves arrive over a valid/ready handshake and are validated inside the block: range check, occupancy check and optional turn enforcement. It keeps a move-history stack so moves can be undone. It sits between the player/computer move sources and the win-check and display logic.

---
 rtl/board_state_regs.sv | 140 ++++++++++++++
 tb/tb_board_state_regs.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/board_state_regs.sv
// rtl/board_state_regs.sv - board-state register file with validated moves and undo history
// Cells hold player codes; the history stack doubles as the occupied-cell count.
module board_state_regs #(
   parameter int BOARD_DIM    = 3,
   parameter int PLAYER_W     = 2,
   parameter int ENFORCE_TURN = 1,
   localparam int NCELL = BOARD_DIM * BOARD_DIM,
   localparam int IDX_W = ($clog2(NCELL) > 1) ? $clog2(NCELL) : 1,
   localparam int CNT_W = $clog2(NCELL + 1)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      clear,
   input  logic                      move_valid,
   output logic                      move_ready,
   input  logic [PLAYER_W-1:0]       move_player,
   input  logic [IDX_W-1:0]          move_idx,
   input  logic                      undo_req,
   output logic                      move_ack,
   output logic                      move_illegal,
   output logic                      undo_err,
   output logic [NCELL*PLAYER_W-1:0] board,
   output logic [CNT_W-1:0]          move_count,
   output logic                      board_full,
   output logic [PLAYER_W-1:0]       last_player
);

   localparam logic [IDX_W:0]   NCELL_I = (IDX_W + 1)'(NCELL);
   localparam logic [CNT_W-1:0] NCELL_C = CNT_W'(NCELL);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [PLAYER_W-1:0] cell_q [NCELL];
   logic [PLAYER_W-1:0] cell_d [NCELL];
   logic [IDX_W-1:0]    hidx_q [NCELL];
   logic [IDX_W-1:0]    hidx_d [NCELL];
   logic [PLAYER_W-1:0] hply_q [NCELL];
   logic [PLAYER_W-1:0] hply_d [NCELL];
   logic [CNT_W-1:0]    sp_q, sp_d;
   logic                ack_q, ack_d;
   logic                ill_q, ill_d;
   logic                uerr_q, uerr_d;

   logic [IDX_W-1:0]    top_ptr;
   logic [IDX_W-1:0]    push_ptr;
   logic                hist_empty;
   logic                full_w;
   logic [PLAYER_W-1:0] last_w;
   logic                in_range;
   logic                occupied;
   logic                turn_clash;
   logic                move_legal;

   // Every occupied cell has exactly one history entry, so sp is the move count.
   assign top_ptr    = IDX_W'(sp_q - ONE_C);
   assign push_ptr   = IDX_W'(sp_q);
   assign hist_empty = (sp_q == '0);
   assign full_w     = (sp_q == NCELL_C);
   assign last_w     = hist_empty ? '0 : hply_q[top_ptr];
   assign in_range   = ({1'b0, move_idx} < NCELL_I);
   assign turn_clash = (ENFORCE_TURN != 0) && (last_w != '0) && (move_player == last_w);

   always_comb begin
      occupied = 1'b0;
      for (int k = 0; k < NCELL; k++) begin
         if (IDX_W'(k) == move_idx && cell_q[k] != '0) occupied = 1'b1;
      end
   end

   assign move_legal = in_range && !occupied && (move_player != '0) && !turn_clash && !full_w;

   always_comb begin
      cell_d = cell_q;
      hidx_d = hidx_q;
      hply_d = hply_q;
      sp_d   = sp_q;
      ack_d  = 1'b0;
      ill_d  = 1'b0;
      uerr_d = 1'b0;
      if (clear) begin
         for (int k = 0; k < NCELL; k++) cell_d[k] = '0;
         sp_d = '0;
      end else if (undo_req) begin
         if (hist_empty) begin
            uerr_d = 1'b1;
         end else begin
            for (int k = 0; k < NCELL; k++) begin
               if (IDX_W'(k) == hidx_q[top_ptr]) cell_d[k] = '0;
            end
            sp_d = sp_q - ONE_C;
         end
      end else if (move_valid) begin
         if (move_legal) begin
            for (int k = 0; k < NCELL; k++) begin
               if (IDX_W'(k) == move_idx) cell_d[k] = move_player;
            end
            hidx_d[push_ptr] = move_idx;
            hply_d[push_ptr] = move_player;
            sp_d  = sp_q + ONE_C;
            ack_d = 1'b1;
         end else begin
            ill_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NCELL; k++) begin
            cell_q[k] <= '0;
            hidx_q[k] <= '0;
            hply_q[k] <= '0;
         end
         sp_q   <= '0;
         ack_q  <= 1'b0;
         ill_q  <= 1'b0;
         uerr_q <= 1'b0;
      end else begin
         cell_q <= cell_d;
         hidx_q <= hidx_d;
         hply_q <= hply_d;
         sp_q   <= sp_d;
         ack_q  <= ack_d;
         ill_q  <= ill_d;
         uerr_q <= uerr_d;
      end
   end

   for (genvar g = 0; g < NCELL; g++) begin : g_board
      assign board[g*PLAYER_W +: PLAYER_W] = cell_q[g];
   end

   assign move_ready   = !clear && !undo_req;
   assign move_ack     = ack_q;
   assign move_illegal = ill_q;
   assign undo_err     = uerr_q;
   assign move_count   = sp_q;
   assign board_full   = full_w;
   assign last_player  = last_w;

endmodule

// File: tb/tb_board_state_regs.sv
// tb/tb_board_state_regs.sv - randomized and directed bench for board_state_regs
// Default instance is tracked by a cell-array/history-queue model; a 4x4 instance covers wider codes.
module tb_board_state_regs;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, clear, move_valid, undo_req;
   logic [1:0]  move_player;
   logic [3:0]  move_idx;
   logic        move_ready, move_ack, move_illegal, undo_err, board_full;
   logic [17:0] board;
   logic [3:0]  move_count;
   logic [1:0]  last_player;

   logic        b_reset_n, b_clear, b_move_valid, b_undo_req;
   logic [2:0]  b_move_player;
   logic [3:0]  b_move_idx;
   logic        b_move_ready, b_move_ack, b_move_illegal, b_undo_err, b_board_full;
   logic [47:0] b_board;
   logic [4:0]  b_move_count;
   logic [2:0]  b_last_player;

   board_state_regs dut_a (
      .clk(clk), .reset_n(reset_n), .clear(clear), .move_valid(move_valid),
      .move_ready(move_ready), .move_player(move_player), .move_idx(move_idx),
      .undo_req(undo_req), .move_ack(move_ack), .move_illegal(move_illegal),
      .undo_err(undo_err), .board(board), .move_count(move_count),
      .board_full(board_full), .last_player(last_player)
   );

   board_state_regs #(.BOARD_DIM(4), .PLAYER_W(3), .ENFORCE_TURN(0)) dut_b (
      .clk(clk), .reset_n(b_reset_n), .clear(b_clear), .move_valid(b_move_valid),
      .move_ready(b_move_ready), .move_player(b_move_player), .move_idx(b_move_idx),
      .undo_req(b_undo_req), .move_ack(b_move_ack), .move_illegal(b_move_illegal),
      .undo_err(b_undo_err), .board(b_board), .move_count(b_move_count),
      .board_full(b_board_full), .last_player(b_last_player)
   );

   typedef struct {
      int idx;
      int ply;
   } hent_t;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    mb [9];
   hent_t hist [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_last();
      return (hist.size() == 0) ? 0 : hist[hist.size()-1].ply;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 9; k++) mb[k] = 0;
      hist.delete();
   endtask

   task automatic check_state_a(input string tag);
      logic [17:0] eb;
      for (int k = 0; k < 9; k++) eb[k*2 +: 2] = 2'(mb[k]);
      check({tag, ".board"}, 64'(board), 64'(eb));
      check({tag, ".count"}, 64'(move_count), 64'(hist.size()));
      check({tag, ".full"}, 64'(board_full), 64'(hist.size() == 9));
      check({tag, ".last"}, 64'(last_player), 64'(model_last()));
   endtask

   task automatic cycle_a(input string tag, input bit v, input int p, input int idx,
                          input bit u, input bit c);
      bit    e_ack, e_ill, e_uerr, legal;
      hent_t h;
      move_valid  = v;
      move_player = 2'(p);
      move_idx    = 4'(idx);
      undo_req    = u;
      clear       = c;
      #1;
      check({tag, ".ready"}, 64'(move_ready), 64'(!(c || u)));
      e_ack = 0; e_ill = 0; e_uerr = 0;
      if (c) begin
         model_reset();
      end else if (u) begin
         if (hist.size() == 0) e_uerr = 1;
         else begin
            h = hist.pop_back();
            mb[h.idx] = 0;
         end
      end else if (v) begin
         legal = (idx < 9) && (p != 0) && (hist.size() < 9) && !(p == model_last() && p != 0);
         if (legal && mb[idx] != 0) legal = 0;
         if (legal) begin
            mb[idx] = p;
            h.idx = idx;
            h.ply = p;
            hist.push_back(h);
            e_ack = 1;
         end else e_ill = 1;
      end
      @(posedge clk);
      #1;
      check({tag, ".ack"}, 64'(move_ack), 64'(e_ack));
      check({tag, ".illegal"}, 64'(move_illegal), 64'(e_ill));
      check({tag, ".undo_err"}, 64'(undo_err), 64'(e_uerr));
      check_state_a(tag);
      move_valid = 0;
      undo_req   = 0;
      clear      = 0;
   endtask

   initial begin
      reset_n = 0; clear = 0; move_valid = 0; undo_req = 0; move_player = 0; move_idx = 0;
      b_reset_n = 0; b_clear = 0; b_move_valid = 0; b_undo_req = 0; b_move_player = 0; b_move_idx = 0;
      model_reset();
      #12;
      check("reset.ack", 64'(move_ack), 64'd0);
      check("reset.illegal", 64'(move_illegal), 64'd0);
      check("reset.undo_err", 64'(undo_err), 64'd0);
      check_state_a("reset");
      @(negedge clk);
      reset_n = 1;
      b_reset_n = 1;
      @(posedge clk);
      #1;

      cycle_a("t1_p1_i4", 1, 1, 4, 0, 0);
      check("t1.cell4", 64'(board[9:8]), 64'd1);
      cycle_a("t2_turn", 1, 1, 0, 0, 0);
      cycle_a("t2_occ", 1, 2, 4, 0, 0);
      cycle_a("t2_range", 1, 2, 9, 0, 0);
      cycle_a("t2_p0", 1, 0, 1, 0, 0);

      cycle_a("t3_clr", 0, 0, 0, 0, 1);
      for (int i = 0; i < 9; i++) cycle_a("t3_fill", 1, (i % 2) + 1, i, 0, 0);
      check("t3.full", 64'(board_full), 64'd1);
      cycle_a("t3_tenth", 1, 2, 0, 0, 0);

      for (int i = 0; i < 3; i++) cycle_a("t4_undo", 0, 0, 0, 1, 0);
      check("t4.count6", 64'(move_count), 64'd6);
      for (int i = 0; i < 6; i++) cycle_a("t4_drain", 0, 0, 0, 1, 0);
      cycle_a("t4_empty", 0, 0, 0, 1, 0);

      cycle_a("t5_mv", 1, 1, 2, 0, 0);
      cycle_a("t5_mv2", 1, 2, 5, 0, 0);
      cycle_a("t5_mv_undo", 1, 1, 7, 1, 0);
      cycle_a("t5_clr_undo", 1, 1, 7, 1, 1);

      for (int i = 0; i < 500; i++) begin
         int r;
         r = $urandom_range(0, 99);
         cycle_a("rand", $urandom_range(0, 4) != 0, $urandom_range(0, 3),
                 $urandom_range(0, 11), (r >= 3 && r < 14), (r < 3));
      end

      b_move_valid = 1; b_move_player = 3'd5; b_move_idx = 4'd15;
      @(posedge clk);
      #1;
      check("t6.ack1", 64'(b_move_ack), 64'd1);
      check("t6.cell15", 64'(b_board[47:45]), 64'd5);
      b_move_idx = 4'd3;
      @(posedge clk);
      #1;
      check("t6.ack2", 64'(b_move_ack), 64'd1);
      check("t6.cell3", 64'(b_board[11:9]), 64'd5);
      check("t6.count", 64'(b_move_count), 64'd2);
      check("t6.last", 64'(b_last_player), 64'd5);
      b_move_valid = 0;
      #2;
      b_reset_n = 0;
      #1;
      check("t6.rst_board", 64'(b_board), 64'd0);
      check("t6.rst_count", 64'(b_move_count), 64'd0);
      check("t6.rst_last", 64'(b_last_player), 64'd0);
      check("t6.rst_ack", 64'(b_move_ack), 64'd0);
      check("t6.rst_full", 64'(b_board_full), 64'd0);

      cycle_a("t7_mv", 1, 2, 8, 0, 0);
      #2;
      reset_n = 0;
      #1;
      model_reset();
      check("t7.rst_ack", 64'(move_ack), 64'd0);
      check_state_a("t7_rst");
      @(negedge clk);
      reset_n = 1;
      b_reset_n = 1;
      @(posedge clk);
      #1;
      cycle_a("t7_after", 1, 1, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
